// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding,
// the default operand width and the full-adder cell used by the ripple adder.
package mul_pkg;

   localparam int MUL_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One full-adder cell; returns {carry_out, sum}.
   function automatic logic [1:0] fullAdd(input logic x, input logic y, input logic cin);
      return {(x & y) | (cin & (x ^ y)), x ^ y ^ cin};
   endfunction

endpackage

// File: rtl/adder_nbit.sv
// Parameterised combinational ripple-carry adder built from full-adder cells.
module adder_nbit
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
);

   logic [WIDTH:0] w_carry;

   // The carry ripples bit by bit inside one process so the chain stays a single comb cone.
   always_comb begin
      sum     = '0;
      w_carry = '0;
      w_carry[0] = c_in;
      for (int i = 0; i < WIDTH; i++) begin
         {w_carry[i+1], sum[i]} = fullAdd(a[i], b[i], w_carry[i]);
      end
   end

   assign c_out = w_carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shift-and-add partial
// product per clock, with a start/busy/done handshake.
module shift_add_multiplier
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int               CNT_W      = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

   state_t               r_state;
   state_t               w_stateNext;
   logic [WIDTH-1:0]     r_mcand;
   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_product;
   logic [CNT_W-1:0]     r_count;
   logic [WIDTH-1:0]     w_addend;
   logic [WIDTH-1:0]     w_sum;
   logic                 w_carry;
   logic [2*WIDTH-1:0]   w_accNext;
   logic                 w_load;
   logic                 w_lastStep;

   assign w_addend = r_acc[0] ? r_mcand : '0;

   adder_nbit #(.WIDTH(WIDTH)) u_adder (
      .a     (r_acc[2*WIDTH-1:WIDTH]),
      .b     (w_addend),
      .c_in  (1'b0),
      .sum   (w_sum),
      .c_out (w_carry)
   );

   // The adder carry becomes the new MSB as the accumulator shifts right.
   assign w_accNext  = {w_carry, w_sum, r_acc[WIDTH-1:1]};
   assign w_load     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_lastStep = (r_state == ST_RUN) && (r_count == LAST_COUNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         ST_IDLE: if (start) w_stateNext = ST_RUN;
         ST_RUN:  if (w_lastStep) w_stateNext = ST_DONE;
         ST_DONE: w_stateNext = start ? ST_RUN : ST_IDLE;
         default: w_stateNext = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand   <= '0;
         r_acc     <= '0;
         r_count   <= '0;
         r_product <= '0;
      end else if (w_load) begin
         r_mcand <= a;
         r_acc   <= {{WIDTH{1'b0}}, b};
         r_count <= '0;
      end else if (r_state == ST_RUN) begin
         r_acc   <= w_accNext;
         r_count <= r_count + CNT_W'(1);
         if (w_lastStep) r_product <= w_accNext;
      end
   end

   assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: a 4-bit instance for directed and
// exhaustive runs, an 8-bit instance for random operands.
module tb_shift_add_multiplier;
   import mul_pkg::*;

   localparam int W4      = 4;
   localparam int W8      = 8;
   localparam int PERIOD  = 10;
   localparam int TIMEOUT = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start4 = 1'b0;
   logic [3:0]  a4 = '0;
   logic [3:0]  b4 = '0;
   logic        busy4, done4;
   logic [7:0]  product4;
   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0;
   logic [7:0]  b8 = '0;
   logic        busy8, done8;
   logic [15:0] product8;

   logic [7:0]  sb4[$];
   logic [15:0] sb8[$];

   int checkCount = 0;
   int passCount  = 0;
   int outstanding = 0;
   int protoErrors = 0;
   int prevDone    = 0;

   shift_add_multiplier #(.WIDTH(W4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .product(product4)
   );

   shift_add_multiplier #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(product8)
   );

   always #(PERIOD/2) clk = ~clk;

   // Protocol watch: one done per accepted start, never busy with done, done one cycle wide.
   always @(negedge clk) begin
      if (!rst_n) begin
         outstanding = 0;
         prevDone    = 0;
      end else begin
         if (busy4 && done4) protoErrors++;
         if (done4) begin
            if (prevDone != 0 || outstanding == 0) protoErrors++;
            else outstanding--;
         end
         prevDone = done4 ? 1 : 0;
         if (start4 && !busy4) outstanding++;
      end
   end

   task automatic startOp4(input logic [3:0] x, input logic [3:0] y);
      a4 = x; b4 = y; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
   endtask

   task automatic waitDone4(output int cycles, output bit timedOut);
      cycles = 0;
      while (done4 !== 1'b1 && cycles < TIMEOUT) begin
         @(posedge clk); #1;
         cycles++;
      end
      timedOut = (done4 !== 1'b1);
   endtask

   task automatic waitDone8(output int cycles, output bit timedOut);
      cycles = 0;
      while (done8 !== 1'b1 && cycles < TIMEOUT) begin
         @(posedge clk); #1;
         cycles++;
      end
      timedOut = (done8 !== 1'b1);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      checkCount++;
      if ({busy4, done4} !== 2'b00) $display("[TB] FAIL reset_flags: busy/done=%b required 00", {busy4, done4});
      else passCount++;
      checkCount++;
      if (product4 !== 8'd0) $display("[TB] FAIL reset_product4: got %0d required 0", product4);
      else passCount++;
      checkCount++;
      if ({busy8, done8, product8} !== 18'd0) $display("[TB] FAIL reset_dut8: got %h required 0", {busy8, done8, product8});
      else passCount++;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int cycles = 0;
      int busyHigh = 0;
      logic [7:0] expected;
      sb4.push_back(8'd143);
      startOp4(4'd13, 4'd11);
      while (done4 !== 1'b1 && cycles < TIMEOUT) begin
         if (busy4 === 1'b1) busyHigh++;
         @(posedge clk); #1;
         cycles++;
      end
      checkCount++;
      if (cycles !== W4) $display("[TB] FAIL basic_latency: got %0d cycles required %0d", cycles, W4);
      else passCount++;
      checkCount++;
      if (busyHigh !== W4) $display("[TB] FAIL basic_busy_width: got %0d cycles required %0d", busyHigh, W4);
      else passCount++;
      expected = sb4.pop_front();
      checkCount++;
      if (product4 !== expected) $display("[TB] FAIL basic_product: got %0d required %0d", product4, expected);
      else passCount++;
      checkCount++;
      if (busy4 !== 1'b0) $display("[TB] FAIL basic_busy_at_done: got %b required 0", busy4);
      else passCount++;
      @(posedge clk); #1;
      checkCount++;
      if ({done4, product4} !== {1'b0, expected}) $display("[TB] FAIL basic_after_done: done/product=%b/%0d required 0/%0d", done4, product4, expected);
      else passCount++;
   endtask

   task automatic test_extremes();
      logic [3:0] opA[3] = '{4'd15, 4'd0, 4'd9};
      logic [3:0] opB[3] = '{4'd15, 4'd9, 4'd0};
      int cycles;
      bit timedOut;
      logic [7:0] expected;
      for (int i = 0; i < 3; i++) begin
         sb4.push_back(8'(int'(opA[i]) * int'(opB[i])));
         startOp4(opA[i], opB[i]);
         waitDone4(cycles, timedOut);
         expected = sb4.pop_front();
         checkCount++;
         if (timedOut || product4 !== expected)
            $display("[TB] FAIL extreme_%0dx%0d: got %0d required %0d (timeout=%0d)", opA[i], opB[i], product4, expected, timedOut);
         else passCount++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int cycles;
      bit timedOut;
      time t1, t2;
      logic [7:0] expected;
      a4 = 4'd3; b4 = 4'd5; start4 = 1'b1;
      sb4.push_back(8'd15);
      @(posedge clk); #1;
      a4 = 4'd7; b4 = 4'd6;
      sb4.push_back(8'd42);
      waitDone4(cycles, timedOut);
      t1 = $time;
      expected = sb4.pop_front();
      checkCount++;
      if (timedOut || product4 !== expected) $display("[TB] FAIL b2b_first: got %0d required %0d", product4, expected);
      else passCount++;
      @(posedge clk); #1;
      start4 = 1'b0;
      checkCount++;
      if ({busy4, done4} !== 2'b10) $display("[TB] FAIL b2b_reload: busy/done=%b required 10", {busy4, done4});
      else passCount++;
      waitDone4(cycles, timedOut);
      t2 = $time;
      expected = sb4.pop_front();
      checkCount++;
      if (timedOut || product4 !== expected) $display("[TB] FAIL b2b_second: got %0d required %0d", product4, expected);
      else passCount++;
      checkCount++;
      if ((t2 - t1) / PERIOD !== W4 + 1) $display("[TB] FAIL b2b_spacing: got %0d cycles required %0d", (t2 - t1) / PERIOD, W4 + 1);
      else passCount++;
      @(posedge clk); #1;
   endtask

   task automatic test_start_during_run();
      int cycles;
      bit timedOut;
      int extraDone = 0;
      int extraBusy = 0;
      logic [7:0] expected;
      sb4.push_back(8'd143);
      startOp4(4'd13, 4'd11);
      @(posedge clk); #1;
      a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      waitDone4(cycles, timedOut);
      expected = sb4.pop_front();
      checkCount++;
      if (timedOut || product4 !== expected) $display("[TB] FAIL run_ignore_product: got %0d required %0d", product4, expected);
      else passCount++;
      for (int i = 0; i < W4 + 2; i++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1) extraDone++;
         if (busy4 === 1'b1) extraBusy++;
      end
      checkCount++;
      if (extraDone !== 0 || extraBusy !== 0) $display("[TB] FAIL run_ignore_second_op: done=%0d busy=%0d cycles required 0/0", extraDone, extraBusy);
      else passCount++;
   endtask

   task automatic test_reset_mid_run();
      int cycles;
      bit timedOut;
      int sawDone = 0;
      logic [7:0] expected;
      startOp4(4'd13, 4'd11);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkCount++;
      if ({busy4, done4, product4} !== 10'd0) $display("[TB] FAIL midrun_reset: busy/done/product=%b/%b/%0d required 0/0/0", busy4, done4, product4);
      else passCount++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < W4 + 2; i++) begin
         @(posedge clk); #1;
         if (done4 === 1'b1) sawDone++;
      end
      checkCount++;
      if (sawDone !== 0 || product4 !== 8'd0) $display("[TB] FAIL midrun_no_done: done=%0d product=%0d required 0/0", sawDone, product4);
      else passCount++;
      sb4.push_back(8'd42);
      startOp4(4'd6, 4'd7);
      waitDone4(cycles, timedOut);
      expected = sb4.pop_front();
      checkCount++;
      if (timedOut || product4 !== expected) $display("[TB] FAIL midrun_recover: got %0d required %0d", product4, expected);
      else passCount++;
      @(posedge clk); #1;
   endtask

   task automatic test_exhaustive4();
      int cycles;
      bit timedOut;
      logic [7:0] expected;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            sb4.push_back(8'(x * y));
            startOp4(4'(x), 4'(y));
            waitDone4(cycles, timedOut);
            expected = sb4.pop_front();
            checkCount++;
            if (timedOut || product4 !== expected)
               $display("[TB] FAIL exhaustive_%0dx%0d: got %0d required %0d (timeout=%0d)", x, y, product4, expected, timedOut);
            else passCount++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random8();
      int cycles;
      bit timedOut;
      int x, y;
      logic [15:0] expected;
      for (int i = 0; i < 40; i++) begin
         x = (i == 0) ? 255 : (i == 1) ? 0 : int'($urandom_range(0, 255));
         y = (i == 0) ? 255 : (i == 1) ? 200 : int'($urandom_range(0, 255));
         sb8.push_back(16'(x * y));
         a8 = 8'(x); b8 = 8'(y); start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0;
         a8 = ~a8; b8 = ~b8;
         waitDone8(cycles, timedOut);
         expected = sb8.pop_front();
         checkCount++;
         if (timedOut || product8 !== expected)
            $display("[TB] FAIL random8_%0dx%0d: got %0d required %0d (timeout=%0d)", x, y, product8, expected, timedOut);
         else passCount++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_protocol();
      @(posedge clk); #1;
      checkCount++;
      if (protoErrors !== 0) $display("[TB] FAIL protocol_violations: got %0d required 0", protoErrors);
      else passCount++;
      checkCount++;
      if (outstanding !== 0) $display("[TB] FAIL protocol_unanswered_starts: got %0d required 0", outstanding);
      else passCount++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_back_to_back();
      test_start_during_run();
      test_reset_mid_run();
      test_exhaustive4();
      test_random8();
      test_protocol();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
